// File: rtl/hpu_bypass_net.sv
// hpu_bypass_net: operand bypass network for the HPU execution cluster.
// SRC_NUM writeback sources are forwarded to RD_NUM read ports, both live and
// from a HIST_DEPTH-deep registered writeback history. Resolution is youngest
// first: live sources, then history stage 0..HIST_DEPTH-1, then the PRF; inside
// each group the lower source index has priority.
// Optional feature macro HPU_BYPASS_PERF_EN adds saturating per-port hit
// counters (CNT_W bits) on hit_cnt_o.
module hpu_bypass_net #(
    parameter int SRC_NUM    = 2,
    parameter int RD_NUM     = 4,
    parameter int HIST_DEPTH = 2,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 7
`ifdef HPU_BYPASS_PERF_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [SRC_NUM-1:0]         src_en_i,
    input  logic [SRC_NUM*IDX_W-1:0]   src_index_i,
    input  logic [SRC_NUM*DATA_W-1:0]  src_data_i,
    input  logic [RD_NUM*IDX_W-1:0]    rd_index_i,
    input  logic [RD_NUM*DATA_W-1:0]   prf_data_i,
    output logic [RD_NUM*DATA_W-1:0]   bypass_data_o,
    output logic [RD_NUM-1:0]          hit_o
`ifdef HPU_BYPASS_PERF_EN
    ,
    output logic [RD_NUM*CNT_W-1:0]    hit_cnt_o
`endif
);

    // Writeback history: stage k holds the broadcasts of k+1 cycles ago.
    logic [HIST_DEPTH-1:0][SRC_NUM-1:0]             hist_vld_r;
    logic [HIST_DEPTH-1:0][SRC_NUM-1:0][IDX_W-1:0]  hist_idx_r;
    logic [HIST_DEPTH-1:0][SRC_NUM-1:0][DATA_W-1:0] hist_data_r;

    // Resolution scratch values, reused for every read port.
    logic [IDX_W-1:0]  rd_idx_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_hit_s;
    logic              match_s;

    // History valids: cleared by reset or flush, otherwise shifted one stage per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_vld_r <= '0;
        end else if (flush_i) begin
            hist_vld_r <= '0;
        end else begin
            hist_vld_r[0] <= src_en_i;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_vld_r[k] <= hist_vld_r[k-1];
            end
        end
    end

    // History payload: shifts every cycle; meaningless whenever its valid is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_idx_r  <= '0;
            hist_data_r <= '0;
        end else begin
            hist_idx_r[0]  <= src_index_i;
            hist_data_r[0] <= src_data_i;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_idx_r[k]  <= hist_idx_r[k-1];
                hist_data_r[k] <= hist_data_r[k-1];
            end
        end
    end

    // Per-port operand select: walk from oldest/lowest priority to youngest/highest
    // so that the last match written is the one that wins.
    always_comb begin
        bypass_data_o = '0;
        hit_o         = '0;
        rd_idx_s      = '0;
        sel_data_s    = '0;
        sel_hit_s     = 1'b0;
        match_s       = 1'b0;
        for (int p = 0; p < RD_NUM; p++) begin
            rd_idx_s   = rd_index_i[p*IDX_W +: IDX_W];
            sel_data_s = prf_data_i[p*DATA_W +: DATA_W];
            sel_hit_s  = 1'b0;
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                for (int s = SRC_NUM - 1; s >= 0; s--) begin
                    match_s    = hist_vld_r[k][s] && (hist_idx_r[k][s] == rd_idx_s);
                    sel_data_s = match_s ? hist_data_r[k][s] : sel_data_s;
                    sel_hit_s  = sel_hit_s | match_s;
                end
            end
            for (int s = SRC_NUM - 1; s >= 0; s--) begin
                match_s    = src_en_i[s] && (src_index_i[s*IDX_W +: IDX_W] == rd_idx_s);
                sel_data_s = match_s ? src_data_i[s*DATA_W +: DATA_W] : sel_data_s;
                sel_hit_s  = sel_hit_s | match_s;
            end
            bypass_data_o[p*DATA_W +: DATA_W] = sel_data_s;
            hit_o[p]                          = sel_hit_s;
        end
    end

`ifdef HPU_BYPASS_PERF_EN
    logic [RD_NUM-1:0][CNT_W-1:0] hit_cnt_r;

    // Saturating per-port hit counters; only reset clears them, flush does not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_r <= '0;
        end else begin
            for (int p = 0; p < RD_NUM; p++) begin
                if (hit_o[p] && (hit_cnt_r[p] != {CNT_W{1'b1}})) begin
                    hit_cnt_r[p] <= hit_cnt_r[p] + CNT_W'(1);
                end else begin
                    hit_cnt_r[p] <= hit_cnt_r[p];
                end
            end
        end
    end

    assign hit_cnt_o = hit_cnt_r;
`endif

endmodule

// File: tb/tb_hpu_bypass_net.sv
// Directed testbench for hpu_bypass_net (default parameters, HIST_DEPTH=2).
// A table of consecutive cycles covers live priority, history aging,
// shadowing, flush and full-width index compare; hand sequences cover reset
// and, when HPU_BYPASS_PERF_EN is defined, counter saturation with CNT_W=4.
module tb_hpu_bypass_net;

    localparam logic [31:0] P0 = 32'h0000_00FF;
    localparam logic [31:0] P1 = 32'h0000_01FF;
    localparam logic [31:0] P2 = 32'h0000_02FF;
    localparam logic [31:0] P3 = 32'h0000_03FF;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   src_en;
    logic [13:0]  src_index;
    logic [63:0]  src_data;
    logic [27:0]  rd_index;
    logic [127:0] prf_data;
    logic [127:0] bypass_data;
    logic [3:0]   hit;
`ifdef HPU_BYPASS_PERF_EN
    logic [15:0]  hit_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hpu_bypass_net #(
        .SRC_NUM(2), .RD_NUM(4), .HIST_DEPTH(2), .DATA_W(32), .IDX_W(7)
`ifdef HPU_BYPASS_PERF_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .src_en_i(src_en),
        .src_index_i(src_index),
        .src_data_i(src_data),
        .rd_index_i(rd_index),
        .prf_data_i(prf_data),
        .bypass_data_o(bypass_data),
        .hit_o(hit)
`ifdef HPU_BYPASS_PERF_EN
        , .hit_cnt_o(hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [6:0]  i0, i1;
        logic [31:0] d0, d1;
        logic        fl;
        logic [6:0]  r0, r1, r2, r3;
        logic [31:0] e0, e1, e2, e3;
        logic [3:0]  eh;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: actual=%0h required=%0h", nm, n, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [6:0] i0, input logic [6:0] i1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic fl,
                         input logic [6:0] r0, input logic [6:0] r1, input logic [6:0] r2,
                         input logic [6:0] r3);
        src_en    = en;
        src_index = {i1, i0};
        src_data  = {d1, d0};
        flush     = fl;
        rd_index  = {r3, r2, r1, r0};
    endtask

    task automatic chk_ports(input string nm, input int n, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input logic [3:0] eh);
        logic [31:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int p = 0; p < 4; p++) begin
            chk(nm, n * 4 + p, bypass_data[p*32 +: 32], ev[p]);
        end
        chk({nm, "_hit"}, n, {28'd0, hit}, {28'd0, eh});
    endtask

    initial begin
        //        en     i0     i1     d0      d1      fl    r0     r1     r2     r3     e0      e1      e2      e3      eh
        vecs[0]  = '{2'b11, 7'd5, 7'd5, 32'hA,  32'hB,  1'b0, 7'd5,  7'd9,  7'd5,  7'd0,  32'hA,  P1,     32'hA,  P3,     4'b0101};
        vecs[1]  = '{2'b01, 7'd9, 7'd9, 32'h11, 32'h22, 1'b0, 7'd9,  7'd5,  7'd9,  7'd1,  32'h11, 32'hA,  32'h11, P3,     4'b0111};
        vecs[2]  = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b0, 7'd9,  7'd5,  7'd0,  7'd9,  32'h11, 32'hA,  P2,     32'h11, 4'b1011};
        vecs[3]  = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b0, 7'd9,  7'd5,  7'd9,  7'd5,  32'h11, P1,     32'h11, P3,     4'b0101};
        vecs[4]  = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b0, 7'd9,  7'd9,  7'd9,  7'd9,  P0,     P1,     P2,     P3,     4'b0000};
        vecs[5]  = '{2'b01, 7'd3, 7'd0, 32'h1,  32'h0,  1'b0, 7'd3,  7'd3,  7'd3,  7'd2,  32'h1,  32'h1,  32'h1,  P3,     4'b0111};
        vecs[6]  = '{2'b10, 7'd3, 7'd3, 32'h5,  32'h2,  1'b0, 7'd3,  7'd3,  7'd3,  7'd3,  32'h2,  32'h2,  32'h2,  32'h2,  4'b1111};
        vecs[7]  = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b0, 7'd3,  7'd3,  7'd3,  7'd3,  32'h2,  32'h2,  32'h2,  32'h2,  4'b1111};
        vecs[8]  = '{2'b01, 7'd4, 7'd0, 32'h7,  32'h0,  1'b1, 7'd4,  7'd3,  7'd4,  7'd8,  32'h7,  32'h2,  32'h7,  P3,     4'b0111};
        vecs[9]  = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b0, 7'd4,  7'd3,  7'd4,  7'd4,  P0,     P1,     P2,     P3,     4'b0000};
        vecs[10] = '{2'b01, 7'd4, 7'd0, 32'h7,  32'h0,  1'b0, 7'd4,  7'd4,  7'd4,  7'd4,  32'h7,  32'h7,  32'h7,  32'h7,  4'b1111};
        vecs[11] = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b1, 7'd4,  7'd4,  7'd4,  7'd4,  32'h7,  32'h7,  32'h7,  32'h7,  4'b1111};
        vecs[12] = '{2'b00, 7'd0, 7'd0, 32'h0,  32'h0,  1'b0, 7'd4,  7'd4,  7'd4,  7'd4,  P0,     P1,     P2,     P3,     4'b0000};
        vecs[13] = '{2'b01, 7'h45, 7'd0, 32'h33, 32'h0, 1'b0, 7'h05, 7'h45, 7'h44, 7'h45, P0,     32'h33, P2,     32'h33, 4'b1010};

        prf_data = {P3, P2, P1, P0};
        rst = 1'b1;
        drive(2'b01, 7'd2, 7'd0, 32'h12, 32'h0, 1'b0, 7'd2, 7'd3, 7'd2, 7'd2);
        #1;
        // In reset: live sources still bypass.
        chk_ports("rst_live", 0, 32'h12, P1, 32'h12, 32'h12, 4'b1101);
`ifdef HPU_BYPASS_PERF_EN
        chk("rst_cnt", 0, {16'd0, hit_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        drive(2'b00, 7'd2, 7'd0, 32'h12, 32'h0, 1'b0, 7'd2, 7'd3, 7'd2, 7'd2);
        #1;
        // Nothing was captured into history while reset was held.
        chk_ports("rst_hist", 0, P0, P1, P2, P3, 4'b0000);
        rst = 1'b0;

        // Table: consecutive cycles, history carries from one vector to the next.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].en, vecs[i].i0, vecs[i].i1, vecs[i].d0, vecs[i].d1, vecs[i].fl,
                  vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
            #3;
            chk_ports("vec", i, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].eh);
        end

        // Reset mid-stream drops history immediately.
        @(posedge clk); #1;
        drive(2'b01, 7'd6, 7'd0, 32'h66, 32'h0, 1'b0, 7'd6, 7'd6, 7'd6, 7'd6);
        #1;
        chk_ports("mid_live", 0, 32'h66, 32'h66, 32'h66, 32'h66, 4'b1111);
        @(posedge clk); #1;
        drive(2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 1'b0, 7'd6, 7'd6, 7'd6, 7'd6);
        #1;
        chk_ports("mid_hist", 0, 32'h66, 32'h66, 32'h66, 32'h66, 4'b1111);
        #1 rst = 1'b1;
        #1;
        chk_ports("mid_rst", 0, P0, P1, P2, P3, 4'b0000);
`ifdef HPU_BYPASS_PERF_EN
        chk("mid_cnt", 0, {16'd0, hit_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk_ports("post_rst", 0, P0, P1, P2, P3, 4'b0000);

`ifdef HPU_BYPASS_PERF_EN
        // Saturating counter: port 1 hits every cycle, other ports never hit.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(2'b01, 7'd10, 7'd0, 32'hAB, 32'h0, 1'b0, 7'd11, 7'd10, 7'd11, 7'd11);
        repeat (5) @(posedge clk);
        #1;
        chk("cnt5_p1", 0, {28'd0, hit_cnt[7:4]}, 32'd5);
        repeat (15) @(posedge clk);
        #1;
        chk("cnt20_p1", 0, {28'd0, hit_cnt[7:4]}, 32'd15);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_sat_p1", 0, {28'd0, hit_cnt[7:4]}, 32'd15);
        chk("cnt_p0", 0, {28'd0, hit_cnt[3:0]}, 32'd0);
        chk("cnt_p2", 0, {28'd0, hit_cnt[11:8]}, 32'd0);
        chk("cnt_p3", 0, {28'd0, hit_cnt[15:12]}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
